// File: rtl/counter_seq_pkg.sv
// Shared definitions for the counter sequencer: FSM state encoding and parameter defaults.
package counter_seq_pkg;

    localparam int unsigned DefWidth      = 4;
    localparam int unsigned DefDepth      = 4;
    localparam int unsigned DefLoadCycles = 2;
    localparam int unsigned DefTimeout    = 64;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StArm,
        StRun
    } state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seq_fifo.sv
// Reload-value FIFO: power-of-two depth, extra pointer bit separates full from empty.
module seq_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
            if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= data;
    end

    assign head  = mem_q[rptr_q[AW-1:0]];
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

endmodule

// File: rtl/counter_sequencer.sv
// Feeds queued reload values to an external counter over a shared bus, starts it and
// collects its terminal pulse, with a RUN timeout.
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int unsigned WIDTH       = DefWidth,
    parameter int unsigned DEPTH       = DefDepth,
    parameter int unsigned LOAD_CYCLES = DefLoadCycles,
    parameter int unsigned TIMEOUT     = DefTimeout
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    inout  wire  [WIDTH-1:0] out_or_load,
    output logic             we,
    output logic             trig,
    input  logic             out_pulse,
    output logic [WIDTH-1:0] readback,
    output logic [7:0]       done_count,
    output logic             busy,
    output logic             timeout_err
);

    localparam int unsigned TW = $clog2(max_u(LOAD_CYCLES, TIMEOUT) + 1);

    state_e           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             pulse_q;
    logic             pulse_edge;
    logic             pop;
    logic             run_done;
    logic             run_tmo;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] head;

    seq_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid && in_ready),
        .pop   (pop),
        .data  (in_data),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    assign pulse_edge = out_pulse && !pulse_q;

    // One timer serves both the LOAD hold and the RUN timeout; it is cleared on every entry.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        pop      = 1'b0;
        trig     = 1'b0;
        we       = 1'b1;
        run_done = 1'b0;
        run_tmo  = 1'b0;
        unique case (state_q)
            StIdle: begin
                timer_d = '0;
                if (!empty) state_d = StLoad;
            end
            StLoad: begin
                we = 1'b0;
                if (timer_q == TW'(LOAD_CYCLES - 1)) begin
                    pop     = 1'b1;
                    timer_d = '0;
                    state_d = StArm;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StArm: begin
                trig    = 1'b1;
                timer_d = '0;
                state_d = StRun;
            end
            StRun: begin
                if (pulse_edge) begin
                    run_done = 1'b1;
                    state_d  = StIdle;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    run_tmo = 1'b1;
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            pulse_q     <= 1'b0;
            readback    <= '0;
            done_count  <= '0;
            timeout_err <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pulse_q <= out_pulse;
            if (state_q == StRun) readback <= out_or_load;
            if (run_done) done_count <= done_count + 8'd1;
            if (run_tmo) timeout_err <= 1'b1;
        end
    end

    // Drive derives from the async-reset state register, so reset releases the bus at once.
    assign out_or_load = we ? 'z : head;
    assign busy        = (state_q != StIdle);
    assign in_ready    = !full;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench: sequencer wired to a behavioural down-counter on the shared bus, scoreboard checking.
module tb_counter_sequencer;

    localparam int W  = 4;
    localparam int D  = 4;
    localparam int LC = 2;
    localparam int TO = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready;
    wire  [W-1:0] out_or_load;
    logic         we;
    logic         trig;
    logic         out_pulse;
    logic [W-1:0] readback;
    logic [7:0]   done_count;
    logic         busy;
    logic         timeout_err;

    // Counter side of the bus.
    logic [W-1:0] cnt = '0;
    logic         running = 1'b0;
    logic         cpulse = 1'b0;
    logic         stub = 1'b0;
    logic         glitch = 1'b0;

    counter_sequencer #(
        .WIDTH       (W),
        .DEPTH       (D),
        .LOAD_CYCLES (LC),
        .TIMEOUT     (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_or_load (out_or_load),
        .we          (we),
        .trig        (trig),
        .out_pulse   (out_pulse),
        .readback    (readback),
        .done_count  (done_count),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #10 clk = ~clk;

    assign out_or_load = we ? cnt : 'z;
    assign out_pulse   = cpulse | glitch;

    always @(posedge clk) begin
        cpulse <= 1'b0;
        if (!we) begin
            cnt <= out_or_load;
        end else if (trig) begin
            running <= !stub;
        end else if (running) begin
            if (cnt == '0) begin
                cpulse  <= 1'b1;
                running <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    int           total = 0;
    int           bad = 0;
    logic [W-1:0] exp_q[$];
    logic [7:0]   exp_done = '0;
    logic         exp_terr = 1'b0;
    int           n_pop = 0;
    int           cyc = 0;
    logic [W-1:0] burst [5] = '{4'd4, 4'd11, 4'd3, 4'd7, 4'd9};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitor: pops the expected load value at the start of each LOAD and checks the run.
    initial begin : monitor
        logic         prev_we;
        logic         prev_trig;
        logic         prev_busy;
        int           load_len;
        int           trig_cyc;
        logic [W-1:0] cur_exp;
        logic [W-1:0] last_load;
        prev_we = 1'b1; prev_trig = 1'b0; prev_busy = 1'b0;
        load_len = 0; trig_cyc = 0; cur_exp = '0; last_load = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_we = 1'b1; prev_trig = 1'b0; prev_busy = 1'b0; load_len = 0;
            end else begin
                chk("bus_known", 32'($isunknown(out_or_load)), 0);
                if (!we) begin
                    if (prev_we) begin
                        chk("idle_gap", prev_busy, 0);
                        if (exp_q.size() == 0) fail_now("unexpected_load");
                        else cur_exp = exp_q.pop_front();
                        load_len = 0;
                    end
                    load_len++;
                    chk("load_bus", out_or_load, cur_exp);
                end else if (!prev_we) begin
                    chk("load_len", load_len, LC);
                    chk("arm_trig", trig, 1);
                    n_pop++;
                    if (!stub) exp_done++;
                    trig_cyc  = cyc;
                    last_load = cur_exp;
                end
                if (trig && prev_trig) fail_now("trig_two_cycles");
                if (prev_busy && !busy) begin
                    chk("done_count", done_count, exp_done);
                    chk("timeout_err", timeout_err, exp_terr);
                    if (stub) begin
                        chk("run_len", cyc - trig_cyc, TO + 1);
                        chk("readback_tmo", readback, last_load);
                    end else begin
                        chk("readback", readback, 0);
                    end
                end
                prev_we = we; prev_trig = trig; prev_busy = busy;
            end
        end
    end

    // Called right after a negedge; returns at the negedge after the value is accepted.
    task automatic push_val(input logic [W-1:0] v);
        logic ok;
        in_valid = 1'b1;
        in_data  = v;
        for (int n = 0; n < 500; n++) begin
            ok = in_ready;
            @(negedge clk);
            if (ok) begin
                exp_q.push_back(v);
                return;
            end
        end
        fail_now("push_timeout");
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0 && !in_valid) return;
        end
        fail_now("idle_timeout");
    endtask

    task automatic wait_pops(input int target);
        for (int n = 0; n < 200; n++) begin
            if (n_pop >= target) return;
            @(negedge clk);
        end
        fail_now("pop_timeout");
    endtask

    initial begin : watchdog
        #1_500_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int pops0;
        logic [7:0] d0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_we", we, 1);
        chk("rst_trig", trig, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done_count, 0);
        chk("rst_terr", timeout_err, 0);
        chk("rst_readback", readback, 0);
        chk("rst_bus_released", out_or_load, cnt);
        rst = 1'b0;
        @(negedge clk);

        // Single value.
        push_val(4'd5);
        in_valid = 1'b0;
        wait_idle();
        chk("first_done", done_count, 1);
        chk("first_busy", busy, 0);

        // Fill the FIFO while a long run is in flight.
        push_val(4'd15);
        in_valid = 1'b0;
        wait_pops(n_pop + 1);
        pops0 = n_pop;
        for (int i = 0; i < 5; i++) begin
            push_val(burst[i]);
            if (i == 3) chk("full_after_4", in_ready, 0);
            if (i == 4) chk("fifth_after_pop", 32'(n_pop > pops0), 1);
        end
        in_valid = 1'b0;
        wait_idle();

        // Random values and gaps.
        for (int i = 0; i < 12; i++) begin
            push_val(4'($urandom_range(0, 15)));
            in_valid = 1'b0;
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end
        wait_idle();

        // out_pulse outside RUN must be ignored.
        d0 = exp_done;
        glitch = 1'b1;
        @(negedge clk);
        glitch = 1'b0;
        repeat (3) @(negedge clk);
        chk("glitch_ignored", done_count, d0);
        chk("glitch_busy", busy, 0);

        // Timeout with a silent counter.
        stub = 1'b1;
        exp_terr = 1'b1;
        push_val(4'd6);
        in_valid = 1'b0;
        wait_idle();
        stub = 1'b0;
        chk("tmo_err", timeout_err, 1);
        chk("tmo_done", done_count, exp_done);
        chk("tmo_idle", busy, 0);

        // Sticky error survives a good run.
        push_val(4'd2);
        in_valid = 1'b0;
        wait_idle();
        chk("tmo_sticky", timeout_err, 1);

        // Reset in the middle of LOAD.
        push_val(4'd12);
        in_valid = 1'b0;
        for (int n = 0; n < 20 && we; n++) @(negedge clk);
        chk("saw_load_12", we, 0);
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_we", we, 1);
        chk("mid_rst_bus", out_or_load, cnt);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_done", done_count, 0);
        chk("mid_rst_terr", timeout_err, 0);
        exp_q.delete();
        exp_done = '0;
        exp_terr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_idle", busy, 0);

        // 256 runs wrap the completed-run counter.
        for (int i = 0; i < 256; i++) push_val(4'd0);
        in_valid = 1'b0;
        wait_idle();
        chk("wrap_done", done_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
